// File: rtl/ysyx_22040895_csr_pkg.sv
// ============================================================================
//  Module      : ysyx_22040895_csr_pkg
//  Description : Shared opcode/state enums, CSR addresses, mstatus bit
//                positions and trap cause codes for the trap/CSR unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_22040895_csr_pkg;

    localparam int C_OP_W = 3;

    typedef enum logic [C_OP_W-1:0] {
        OP_NOP    = 3'd0,
        OP_ECALL  = 3'd1,
        OP_MRET   = 3'd2,
        OP_CSRRS  = 3'd3,
        OP_CSRRW  = 3'd4,
        OP_CSRRC  = 3'd5,
        OP_EBREAK = 3'd6
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam logic [11:0] C_ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] C_ADDR_MIE      = 12'h304;
    localparam logic [11:0] C_ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] C_ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] C_ADDR_MEPC     = 12'h341;
    localparam logic [11:0] C_ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] C_ADDR_MIP      = 12'h344;

    localparam int C_MSTATUS_MIE    = 3;
    localparam int C_MSTATUS_MPIE   = 7;
    localparam int C_MSTATUS_MPP_LO = 11;
    localparam int C_MSTATUS_MPP_HI = 12;
    localparam int C_MIE_MTIE       = 7;
    localparam int C_MIP_MTIP       = 7;

    localparam int C_CAUSE_ILLEGAL  = 2;
    localparam int C_CAUSE_BREAK    = 3;
    localparam int C_CAUSE_ECALL_M  = 11;
    localparam int C_CAUSE_MTI      = 7;

    function automatic logic is_csr_op(input op_e op);
        return (op == OP_CSRRS) || (op == OP_CSRRW) || (op == OP_CSRRC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22040895_csr_regfile.sv
// ============================================================================
//  Module      : ysyx_22040895_csr_regfile
//  Description : Machine-mode CSR storage, read decode and legal-address flag.
//                YSYX_22040895_TIMER_IRQ_EN makes mip.MTIP mirror mtip_i.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040895_csr_regfile
    import ysyx_22040895_csr_pkg::*;
#(
    parameter int               XLEN        = 64,
    parameter logic [XLEN-1:0]  RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     addr_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            legal_o,
    input  logic            we_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_epc_i,
    input  logic            mret_i,
    input  logic            mtip_i,
    output logic            mstatus_mie_o,
    output logic            mie_mtie_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o
);

    logic [XLEN-1:0] r_mstatus_q;
    logic [XLEN-1:0] r_mie_q;
    logic [XLEN-1:0] r_mtvec_q;
    logic [XLEN-1:0] r_mscratch_q;
    logic [XLEN-1:0] r_mepc_q;
    logic [XLEN-1:0] r_mcause_q;
    logic [XLEN-1:0] w_mip;

`ifdef YSYX_22040895_TIMER_IRQ_EN
    assign w_mip = XLEN'(mtip_i) << C_MIP_MTIP;
`else
    logic w_unused_mtip;
    assign w_mip         = '0;
    assign w_unused_mtip = mtip_i;
`endif

    always_comb begin
        legal_o = 1'b1;
        rdata_o = '0;
        case (addr_i)
            C_ADDR_MSTATUS:  rdata_o = r_mstatus_q;
            C_ADDR_MIE:      rdata_o = r_mie_q;
            C_ADDR_MTVEC:    rdata_o = r_mtvec_q;
            C_ADDR_MSCRATCH: rdata_o = r_mscratch_q;
            C_ADDR_MEPC:     rdata_o = r_mepc_q;
            C_ADDR_MCAUSE:   rdata_o = r_mcause_q;
            C_ADDR_MIP:      rdata_o = w_mip;
            default:         legal_o = 1'b0;
        endcase
    end

    // The top guarantees trap, mret and write are mutually exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_q  <= '0;
            r_mie_q      <= '0;
            r_mtvec_q    <= RESET_MTVEC;
            r_mscratch_q <= '0;
            r_mepc_q     <= '0;
            r_mcause_q   <= '0;
        end else if (trap_i) begin
            r_mepc_q                                       <= trap_epc_i;
            r_mcause_q                                     <= trap_cause_i;
            r_mstatus_q[C_MSTATUS_MPIE]                    <= r_mstatus_q[C_MSTATUS_MIE];
            r_mstatus_q[C_MSTATUS_MIE]                     <= 1'b0;
            r_mstatus_q[C_MSTATUS_MPP_HI:C_MSTATUS_MPP_LO] <= 2'b11;
        end else if (mret_i) begin
            r_mstatus_q[C_MSTATUS_MIE]                     <= r_mstatus_q[C_MSTATUS_MPIE];
            r_mstatus_q[C_MSTATUS_MPIE]                    <= 1'b1;
            r_mstatus_q[C_MSTATUS_MPP_HI:C_MSTATUS_MPP_LO] <= 2'b00;
        end else if (we_i) begin
            case (addr_i)
                C_ADDR_MSTATUS:  r_mstatus_q  <= wdata_i;
                C_ADDR_MIE:      r_mie_q      <= wdata_i;
                C_ADDR_MTVEC:    r_mtvec_q    <= {wdata_i[XLEN-1:2], 1'b0, wdata_i[0]};
                C_ADDR_MSCRATCH: r_mscratch_q <= wdata_i;
                C_ADDR_MEPC:     r_mepc_q     <= {wdata_i[XLEN-1:2], 2'b00};
                C_ADDR_MCAUSE:   r_mcause_q   <= wdata_i;
                default:         ;
            endcase
        end
    end

    assign mstatus_mie_o = r_mstatus_q[C_MSTATUS_MIE];
    assign mie_mtie_o    = r_mie_q[C_MIE_MTIE];
    assign mtvec_o       = r_mtvec_q;
    assign mepc_o        = r_mepc_q;

endmodule

`default_nettype wire

// File: rtl/ysyx_22040895_trap_csr_unit.sv
// ============================================================================
//  Module      : ysyx_22040895_trap_csr_unit
//  Description : CSR op execution, trap/mret sequencing and IFU redirect.
//                YSYX_22040895_TIMER_IRQ_EN enables the machine timer IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22040895_trap_csr_unit
    import ysyx_22040895_csr_pkg::*;
#(
    parameter int               XLEN        = 64,
    parameter int               OP_W        = 3,
    parameter logic [XLEN-1:0]  RESET_MTVEC = 'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid_i,
    output logic            op_ready_o,
    input  logic [OP_W-1:0] op_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            mtip_i
);

    state_e          r_state_q;
    logic            r_resp_valid_q;
    logic [XLEN-1:0] r_result_q;
    logic            r_redirect_q;
    logic [XLEN-1:0] r_redirect_pc_q;

    op_e             w_op;
    logic            w_accept;
    logic            w_is_csr;
    logic            w_legal;
    logic            w_irq;
    logic            w_illegal;
    logic            w_trap;
    logic            w_csr_we;
    logic            w_mret;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_result_d;
    logic            w_redirect_d;
    logic [XLEN-1:0] w_redirect_pc_d;
    logic            w_mstatus_mie;
    logic            w_mie_mtie;
    logic [XLEN-1:0] w_mtvec;
    logic [XLEN-1:0] w_mepc;

    assign w_op       = op_e'(op_i);
    assign op_ready_o = (r_state_q == ST_IDLE);
    assign w_accept   = op_valid_i & op_ready_o;
    assign w_is_csr   = is_csr_op(w_op);

`ifdef YSYX_22040895_TIMER_IRQ_EN
    assign w_irq = w_mstatus_mie & w_mie_mtie & mtip_i;
`else
    logic w_unused_irq;
    assign w_irq        = 1'b0;
    assign w_unused_irq = ^{w_mstatus_mie, w_mie_mtie, w_mtvec[1:0]};
`endif

    // A pending interrupt pre-empts the offered op entirely.
    assign w_illegal = ~w_irq & w_is_csr & ~w_legal;
    assign w_trap    = w_irq | w_illegal | (w_op == OP_ECALL) | (w_op == OP_EBREAK);
    assign w_csr_we  = w_accept & ~w_irq & w_is_csr & w_legal;
    assign w_mret    = w_accept & ~w_irq & (w_op == OP_MRET);
    assign w_base    = {w_mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        case (w_op)
            OP_CSRRW: w_wdata = rs1_i;
            OP_CSRRS: w_wdata = w_rdata | rs1_i;
            OP_CSRRC: w_wdata = w_rdata & ~rs1_i;
            default:  w_wdata = w_rdata;
        endcase
    end

    always_comb begin
        w_cause         = '0;
        w_redirect_d    = 1'b0;
        w_redirect_pc_d = '0;
        w_result_d      = (~w_irq & w_is_csr & w_legal) ? w_rdata : '0;
        if (w_irq) begin
            w_cause         = {1'b1, (XLEN-1)'(C_CAUSE_MTI)};
            w_redirect_d    = 1'b1;
            w_redirect_pc_d = (w_mtvec[1:0] == 2'b01) ? w_base + XLEN'(4 * C_CAUSE_MTI) : w_base;
        end else if (w_illegal) begin
            w_cause         = XLEN'(C_CAUSE_ILLEGAL);
            w_redirect_d    = 1'b1;
            w_redirect_pc_d = w_base;
        end else if (w_op == OP_ECALL) begin
            w_cause         = XLEN'(C_CAUSE_ECALL_M);
            w_redirect_d    = 1'b1;
            w_redirect_pc_d = w_base;
        end else if (w_op == OP_EBREAK) begin
            w_cause         = XLEN'(C_CAUSE_BREAK);
            w_redirect_d    = 1'b1;
            w_redirect_pc_d = w_base;
        end else if (w_op == OP_MRET) begin
            w_redirect_d    = 1'b1;
            w_redirect_pc_d = w_mepc;
        end
    end

    ysyx_22040895_csr_regfile #(
        .XLEN        (XLEN),
        .RESET_MTVEC (RESET_MTVEC)
    ) u_regfile (
        .clk           (clk),
        .rst           (rst),
        .addr_i        (csr_addr_i),
        .rdata_o       (w_rdata),
        .legal_o       (w_legal),
        .we_i          (w_csr_we),
        .wdata_i       (w_wdata),
        .trap_i        (w_accept & w_trap),
        .trap_cause_i  (w_cause),
        .trap_epc_i    (pc_i),
        .mret_i        (w_mret),
        .mtip_i        (mtip_i),
        .mstatus_mie_o (w_mstatus_mie),
        .mie_mtie_o    (w_mie_mtie),
        .mtvec_o       (w_mtvec),
        .mepc_o        (w_mepc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= ST_IDLE;
            r_resp_valid_q  <= 1'b0;
            r_result_q      <= '0;
            r_redirect_q    <= 1'b0;
            r_redirect_pc_q <= '0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state_q       <= ST_RESP;
                        r_resp_valid_q  <= 1'b1;
                        r_result_q      <= w_result_d;
                        r_redirect_q    <= w_redirect_d;
                        r_redirect_pc_q <= w_redirect_pc_d;
                    end
                end
                ST_RESP: begin
                    r_state_q       <= ST_IDLE;
                    r_resp_valid_q  <= 1'b0;
                    r_result_q      <= '0;
                    r_redirect_q    <= 1'b0;
                    r_redirect_pc_q <= '0;
                end
                default: r_state_q <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid_o  = r_resp_valid_q;
    assign result_o      = r_result_q;
    assign redirect_o    = r_redirect_q;
    assign redirect_pc_o = r_redirect_pc_q;

endmodule

`default_nettype wire
